// File: rtl/lemmings_pkg.sv
// rtl/lemmings_pkg.sv - shared types and constants for the lemmings terrain model
// Contents: default geometry, height_t/pos_t, world_state_e, fall length saturation helper.
package lemmings_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int H_W_DEF   = 5;
    localparam int POS_W_DEF = $clog2(WIDTH_DEF);

    typedef logic [H_W_DEF-1:0]   height_t;
    typedef logic [POS_W_DEF-1:0] pos_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } world_state_e;

    localparam int FALL_LEN_MAX = 31;
    localparam int FALL_W       = 5;

    function automatic logic [FALL_W-1:0] fall_sat_inc(input logic [FALL_W-1:0] v);
        if (v == FALL_W'(FALL_LEN_MAX)) begin
            return v;
        end
        return v + FALL_W'(1);
    endfunction

endpackage

// File: rtl/lemmings_world_if.sv
// rtl/lemmings_world_if.sv - walker <-> world feedback loop signals
// Signals: walk_left/walk_right/aaah/digging (walker -> world),
//          ground/bump_left/bump_right/dig (world -> walker).
// Modports: master = world side, slave = walker side.
interface lemmings_world_if;
    logic walk_left;
    logic walk_right;
    logic aaah;
    logic digging;
    logic ground;
    logic bump_left;
    logic bump_right;
    logic dig;

    modport master (
        input  walk_left, walk_right, aaah, digging,
        output ground, bump_left, bump_right, dig
    );

    modport slave (
        output walk_left, walk_right, aaah, digging,
        input  ground, bump_left, bump_right, dig
    );
endinterface

// File: rtl/lemmings_height_map.sv
// rtl/lemmings_height_map.sv - WIDTH x H_W height register file
// Ports: clk, rst_n (async, active low, clears all heights to bedrock),
//        we/waddr/wdata (single write port),
//        raddr_a/rdata_a, raddr_b/rdata_b (two asynchronous read ports).
module lemmings_height_map #(
    parameter  int WIDTH = 16,
    parameter  int H_W   = 5,
    localparam int POS_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [POS_W-1:0] waddr,
    input  logic [H_W-1:0]   wdata,
    input  logic [POS_W-1:0] raddr_a,
    output logic [H_W-1:0]   rdata_a,
    input  logic [POS_W-1:0] raddr_b,
    output logic [H_W-1:0]   rdata_b
);

    logic [H_W-1:0] mem [WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/lemmings_world.sv
// rtl/lemmings_world.sv - 1-D terrain model closing the loop around the lemming walker FSM
// Ports: clk, areset_n (async, active low);
//        cfg_we/cfg_col/cfg_height (height map write), start, dig_req (game controller);
//        walker (lemmings_world_if.master: walker inputs in, ground/bump/dig out);
//        pos, alt, fall_len (status).
// Build option: LEMMINGS_WORLD_WRAP_EN makes columns wrap around instead of bumping at the edges.
module lemmings_world
    import lemmings_pkg::*;
#(
    parameter  int WIDTH       = WIDTH_DEF,
    parameter  int H_W         = H_W_DEF,
    parameter  int STEP_CYCLES = 4,
    parameter  int DIG_CYCLES  = 3,
    parameter  int START_POS   = 0,
    localparam int POS_W       = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                areset_n,
    input  logic                cfg_we,
    input  logic [POS_W-1:0]    cfg_col,
    input  logic [H_W-1:0]      cfg_height,
    input  logic                start,
    input  logic                dig_req,
    lemmings_world_if.master    walker,
    output logic [POS_W-1:0]    pos,
    output logic [H_W-1:0]      alt,
    output logic [FALL_W-1:0]   fall_len
);

    localparam int SC_W = $clog2(STEP_CYCLES + 1);
    localparam int DC_W = $clog2(DIG_CYCLES + 1);
    localparam logic [H_W-1:0]   H_ONE    = 1;
    localparam logic [POS_W-1:0] POS_ONE  = 1;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(WIDTH - 1);
    localparam logic [POS_W-1:0] POS_INIT = POS_W'(START_POS);

    world_state_e      state;
    logic [SC_W-1:0]   step_cnt;
    logic [DC_W-1:0]   dig_cnt;
    logic [FALL_W-1:0] fall_cnt;
    logic              aaah_d;
    logic              bump_left_q;
    logic              bump_right_q;
    logic              dig_q;

    logic [H_W-1:0]    h_pos;
    logic [H_W-1:0]    h_tgt;
    logic [POS_W-1:0]  tgt;
    logic [POS_W-1:0]  rd_b_addr;
    logic              at_edge;
    logic              edge_block;
    logic              run;
    logic              on_ground;
    logic              walking;
    logic              step_fire;
    logic              move_block;
    logic              dig_active;
    logic              dig_fire;
    logic              dig_dec;
    logic              dig_retry;
    logic              map_we;
    logic [POS_W-1:0]  map_waddr;
    logic [H_W-1:0]    map_wdata;

    // Left wins if the walker ever asserts both directions.
    always_comb begin
        tgt     = pos;
        at_edge = 1'b0;
        if (walker.walk_left) begin
            if (pos == '0) begin
                at_edge = 1'b1;
                tgt     = POS_LAST;
            end else begin
                tgt = pos - POS_ONE;
            end
        end else begin
            if (pos == POS_LAST) begin
                at_edge = 1'b1;
                tgt     = '0;
            end else begin
                tgt = pos + POS_ONE;
            end
        end
    end

`ifdef LEMMINGS_WORLD_WRAP_EN
    assign edge_block = 1'b0;
`else
    assign edge_block = at_edge;
`endif

    // The target read port doubles as the START_POS lookup on a start cycle.
    assign rd_b_addr  = start ? POS_INIT : tgt;

    assign run        = (state == RUN);
    assign on_ground  = (alt == h_pos);
    assign walking    = run && on_ground && (walker.walk_left || walker.walk_right) && !start;
    assign step_fire  = walking && (step_cnt == SC_W'(STEP_CYCLES - 1));
    assign move_block = edge_block || (h_tgt > alt);
    assign dig_active = run && on_ground && walker.digging && !start;
    assign dig_fire   = dig_active && (dig_cnt == DC_W'(DIG_CYCLES - 1));
    assign dig_dec    = dig_fire && (h_pos != '0);

    // A map write always owns the single write port. If it hits another column the
    // decrement is not lost: the dig timer is held at its final count and retries.
    assign dig_retry  = dig_dec && cfg_we && (cfg_col != pos);

    always_comb begin
        map_we    = 1'b0;
        map_waddr = pos;
        map_wdata = h_pos - H_ONE;
        if (cfg_we) begin
            map_we    = 1'b1;
            map_waddr = cfg_col;
            map_wdata = cfg_height;
        end else if (dig_dec) begin
            map_we    = 1'b1;
        end
    end

    lemmings_height_map #(
        .WIDTH (WIDTH),
        .H_W   (H_W)
    ) u_height_map (
        .clk     (clk),
        .rst_n   (areset_n),
        .we      (map_we),
        .waddr   (map_waddr),
        .wdata   (map_wdata),
        .raddr_a (pos),
        .rdata_a (h_pos),
        .raddr_b (rd_b_addr),
        .rdata_b (h_tgt)
    );

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state        <= IDLE;
            pos          <= '0;
            alt          <= '0;
            step_cnt     <= '0;
            dig_cnt      <= '0;
            fall_cnt     <= '0;
            fall_len     <= '0;
            aaah_d       <= 1'b0;
            bump_left_q  <= 1'b0;
            bump_right_q <= 1'b0;
            dig_q        <= 1'b0;
        end else begin
            bump_left_q  <= 1'b0;
            bump_right_q <= 1'b0;

            if (dig_req) begin
                dig_q <= 1'b1;
            end else if (walker.digging || start) begin
                dig_q <= 1'b0;
            end

            aaah_d <= walker.aaah;
            if (walker.aaah) begin
                fall_cnt <= fall_sat_inc(fall_cnt);
            end else if (aaah_d) begin
                fall_len <= fall_cnt;
                fall_cnt <= '0;
            end

            if (start) begin
                state    <= RUN;
                pos      <= POS_INIT;
                alt      <= h_tgt;
                step_cnt <= '0;
                dig_cnt  <= '0;
            end else if (run) begin
                // Falls one level per cycle; a raised column under the lemming lifts it.
                if (alt > h_pos) begin
                    alt <= alt - H_ONE;
                end else if (alt < h_pos) begin
                    alt <= h_pos;
                end

                if (!walking || step_fire) begin
                    step_cnt <= '0;
                end else begin
                    step_cnt <= step_cnt + SC_W'(1);
                end

                if (step_fire) begin
                    if (move_block) begin
                        bump_left_q  <= walker.walk_left;
                        bump_right_q <= !walker.walk_left;
                    end else begin
                        pos <= tgt;
                    end
                end

                if (!dig_active) begin
                    dig_cnt <= '0;
                end else if (dig_fire) begin
                    if (!dig_retry) begin
                        dig_cnt <= '0;
                    end
                end else begin
                    dig_cnt <= dig_cnt + DC_W'(1);
                end
            end else begin
                step_cnt <= '0;
                dig_cnt  <= '0;
            end
        end
    end

    assign walker.ground     = !run || on_ground;
    assign walker.bump_left  = bump_left_q;
    assign walker.bump_right = bump_right_q;
    assign walker.dig        = dig_q;

endmodule
